// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between icache refills and dcache transfers, running
// critical-word-first wrapping bursts. Define MEM_ARB_RR_EN for round-robin on simultaneous requests.
module mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_word,
   output logic              ic_word_ready,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic [DATA_W-1:0] dc_word,
   output logic              dc_word_ready,
   output logic              dc_done,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ready
);

   localparam int IDX_W  = $clog2(BURST_LEN);
   localparam int BASE_W = ADDR_W - IDX_W - 2;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, I_BURST, D_BURST, TURN} state_t;

   state_t            state;
   logic [BASE_W-1:0] base;
   logic [IDX_W-1:0]  start;
   logic [IDX_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic              we_lat;
   logic              grant_d;
   logic              in_burst;
   logic              last;
   logic              unused_addr_lsbs;

   // Byte-offset bits never reach RAM: bursts are word aligned.
   assign unused_addr_lsbs = ^{ic_addr[1:0], dc_addr[1:0]};

`ifdef MEM_ARB_RR_EN
   logic last_dc;
   assign grant_d = dc_req && (!ic_req || !last_dc);
`else
   assign grant_d = dc_req;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         base   <= '0;
         start  <= '0;
         cnt    <= '0;
         we_lat <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_dc <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_d) begin
                  state  <= D_BURST;
                  base   <= dc_addr[ADDR_W-1:IDX_W+2];
                  start  <= dc_addr[IDX_W+1:2];
                  we_lat <= dc_we;
`ifdef MEM_ARB_RR_EN
                  last_dc <= 1'b1;
`endif
               end else if (ic_req) begin
                  state  <= I_BURST;
                  base   <= ic_addr[ADDR_W-1:IDX_W+2];
                  start  <= ic_addr[IDX_W+1:2];
                  we_lat <= 1'b0;
`ifdef MEM_ARB_RR_EN
                  last_dc <= 1'b0;
`endif
               end
            end
            I_BURST, D_BURST: begin
               if (ram_ready) begin
                  cnt <= cnt + 1'b1;
                  if (last) state <= TURN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode from registered state, so async reset clears them at once.
   assign in_burst  = (state == I_BURST) || (state == D_BURST);
   assign last      = (cnt == LAST);
   assign idx       = start + cnt;
   assign ram_req   = in_burst;
   assign ram_we    = (state == D_BURST) && we_lat;
   assign ram_addr  = in_burst ? {base, idx, 2'b00} : '0;
   assign ram_wdata = ram_we ? dc_wdata : '0;

   assign ic_word_ready = (state == I_BURST) && ram_ready;
   assign ic_done       = ic_word_ready && last;
   assign ic_word       = ic_word_ready ? ram_rdata : '0;

   assign dc_word_ready = (state == D_BURST) && ram_ready;
   assign dc_done       = dc_word_ready && last;
   assign dc_word       = (dc_word_ready && !we_lat) ? ram_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external RAM port between instruction-cache refills and data-cache transfers.
- Sits between the fetch unit's icache controller, the dcache controller, and RAM.
- Grants one requester at a time and runs a fixed-length, critical-word-first burst.
- Returns each RAM word to the owner with a per-word strobe and signals burst completion.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, RAM word width.
- BURST_LEN, 4, words per cache block; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_req  in  1  icache refill request; held until ic_done.
- ic_addr  in  ADDR_W  missing instruction byte address.
- ic_word  out  DATA_W  refill word to icache.
- ic_word_ready  out  1  one-cycle strobe: ic_word valid.
- ic_done  out  1  one-cycle strobe with the last word.
- dc_req  in  1  dcache transfer request; held until dc_done.
- dc_we  in  1  1 = write-back burst, 0 = refill burst.
- dc_addr  in  ADDR_W  dcache byte address.
- dc_wdata  in  DATA_W  current write word; dcache advances it on each dc_word_ready.
- dc_word  out  DATA_W  refill word to dcache.
- dc_word_ready  out  1  one-cycle strobe: word transferred (read or write).
- dc_done  out  1  one-cycle strobe with the last word.
- ram_req  out  1  RAM access active.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address; low 2 bits are always 0.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM completed the current word this cycle.

Behaviour:
- States: IDLE, I_BURST, D_BURST, TURN.
- Reset (async, any state, mid-burst included):
  - State returns to IDLE; word counter clears to 0; burst is abandoned.
  - All outputs 0, including ic_word and dc_word.
- IDLE:
  - dc_req=1 → D_BURST (dcache wins when both request).
  - Else ic_req=1 → I_BURST.
  - Else stay in IDLE.
  - On grant, latch: block base = addr[ADDR_W-1 : log2(BURST_LEN)+2]; start index = addr[log2(BURST_LEN)+1 : 2]; dc_we (D only).
  - Grant decision is registered: ram_req rises the cycle after the request is seen.
- I_BURST / D_BURST:
  - ram_req=1.
  - ram_we = latched dc_we in D_BURST, 0 in I_BURST.
  - ram_addr = {base, (start+cnt) mod BURST_LEN, 2'b00}: wraps inside the block, critical word first.
  - ram_wdata = dc_wdata (combinational pass-through), D write only; otherwise 0.
- On each ram_ready=1:
  - Owner's *_word_ready pulses the same cycle.
  - Owner's *_word = ram_rdata, combinational pass-through (undefined for writes).
  - cnt increments.
  - The non-owner's outputs stay 0.
- Last word (cnt=BURST_LEN-1 with ram_ready):
  - *_done pulses together with *_word_ready.
  - Next state is TURN.
- TURN: one cycle, all RAM outputs 0, then IDLE. No back-to-back bursts; minimum gap is 2 cycles between bursts.
- Request line and address changes during a burst are ignored; the burst always completes.
- A requester whose req is still high after done is re-arbitrated normally in IDLE.
- ram_ready outside a burst is ignored.
- Wait states: ram_ready may stay low for any number of cycles; ram_addr, ram_we and ram_req hold stable.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: a 1-bit last-owner register (reset = icache).
  - When both requests are high in IDLE, the requester not served last wins.
  - A single request is granted immediately.
- Undefined: fixed dcache priority as described above; no last-owner register.

Test Plan:
- ic_req, ic_addr=0x0000_0108, BURST_LEN=4, ram_ready always 1 → ram_addr sequence 0x108, 0x10C, 0x100, 0x104; four ic_word_ready pulses; ic_done on the 4th; ram_we=0.
- dc_req with dc_we=1, dc_addr=0x200, ram_ready every 3rd cycle → ram_addr holds between readies; ram_wdata follows dc_wdata words A0..A3; dc_done after 4 readies; ic outputs stay 0.
- ic_req and dc_req rise on the same cycle:
  - Feature off → D burst first, then TURN, IDLE, then I burst.
  - Feature on, after reset → dcache first, then icache; a repeat simultaneous request goes to dcache again.
- ic_req dropped and ic_addr changed mid-burst → burst completes at the original addresses with 4 strobes.
- rst asserted asynchronously during word 2 of a D burst → all outputs 0 immediately; after release with ic_req high, an I burst starts from cnt 0.
- ram_ready pulsed while IDLE with no requests → no strobes, state stays IDLE.
